// File: rtl/sevenseg_scan_decoder.sv
// Multiplexed 7-segment readback monitor: recovers the displayed 4-digit hex value
// from sampled segment/enable lines, rejecting ghosting and unconfirmed frames.
module sevenseg_scan_decoder #(
   parameter int SETTLE_CYCLES  = 4,
   parameter int CONFIRM_FRAMES = 2,
   parameter int TIMEOUT_CYCLES = 65535,
   parameter bit EN_ACTIVE_LOW  = 1'b0,
   parameter bit SEG_ACTIVE_LOW = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  seg_in,
   input  logic [3:0]  en_in,
   output logic [15:0] value_out,
   output logic [3:0]  dp_out,
   output logic [3:0]  blank_out,
   output logic        value_valid,
   output logic        pattern_err,
   output logic        display_lost
);

   localparam int SW = $clog2(SETTLE_CYCLES + 1);
   localparam int CW = $clog2(CONFIRM_FRAMES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE_CYCLES);
   localparam logic [SW-1:0] SETTLE_ONE  = SW'(1'b1);
   localparam logic [CW-1:0] CONFIRM_MAX = CW'(CONFIRM_FRAMES);
   localparam logic [CW-1:0] CONFIRM_ONE = CW'(1'b1);
   localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TIMEOUT_ONE = TW'(1'b1);

   typedef enum logic [1:0] {
      WAIT_EN  = 2'd0,
      SETTLING = 2'd1,
      HELD     = 2'd2
   } state_t;

   // Returns {decodable, blank, nibble} for an A-G segment pattern.
   function automatic logic [5:0] decode_seg(input logic [6:0] s);
      logic [5:0] r;
      case (s)
         7'h3F:   r = {2'b10, 4'h0};
         7'h06:   r = {2'b10, 4'h1};
         7'h5B:   r = {2'b10, 4'h2};
         7'h4F:   r = {2'b10, 4'h3};
         7'h66:   r = {2'b10, 4'h4};
         7'h6D:   r = {2'b10, 4'h5};
         7'h7D:   r = {2'b10, 4'h6};
         7'h07:   r = {2'b10, 4'h7};
         7'h7F:   r = {2'b10, 4'h8};
         7'h6F:   r = {2'b10, 4'h9};
         7'h77:   r = {2'b10, 4'hA};
         7'h7C:   r = {2'b10, 4'hB};
         7'h39:   r = {2'b10, 4'hC};
         7'h5E:   r = {2'b10, 4'hD};
         7'h79:   r = {2'b10, 4'hE};
         7'h71:   r = {2'b10, 4'hF};
         7'h00:   r = {2'b11, 4'h0};
         default: r = {2'b00, 4'h0};
      endcase
      return r;
   endfunction

   function automatic logic is_one_hot(input logic [3:0] e);
      return (e != 4'h0) && ((e & (e - 4'h1)) == 4'h0);
   endfunction

   function automatic logic [1:0] onehot_index(input logic [3:0] e);
      logic [1:0] r;
      case (e)
         4'b0010: r = 2'd1;
         4'b0100: r = 2'd2;
         4'b1000: r = 2'd3;
         default: r = 2'd0;
      endcase
      return r;
   endfunction

   logic [7:0]    seg_meta_r, seg_sync_r, seg_prev_r;
   logic [3:0]    en_meta_r, en_sync_r, en_prev_r;
   logic [7:0]    seg_s;
   logic [3:0]    en_s;
   logic          en_changed_s, seg_changed_s, en_one_hot_s;

   state_t        state_r, state_nxt;
   logic [SW-1:0] settle_r, settle_nxt;
   logic          capture_s;

   logic [5:0]    dec_s;
   logic [1:0]    idx_s;
   logic [15:0]   wval_r, wval_nxt, prev_val_r;
   logic [3:0]    wdp_r, wdp_nxt, prev_dp_r;
   logic [3:0]    wblank_r, wblank_nxt, prev_blank_r;
   logic [3:0]    seen_r, seen_nxt;
   logic          inv_r, inv_nxt;
   logic          frame_done_s, match_s, confirm_s, differs_s;
   logic [CW-1:0] conf_r, conf_nxt;
   logic [TW-1:0] tmo_r, tmo_nxt;
   logic          tmo_hit_s;

   logic [15:0]   value_r;
   logic [3:0]    dp_r, blank_r;
   logic          valid_r, perr_r, lost_r, has_out_r;

   assign seg_s         = seg_sync_r ^ {8{SEG_ACTIVE_LOW}};
   assign en_s          = en_sync_r ^ {4{EN_ACTIVE_LOW}};
   assign en_changed_s  = (en_s != en_prev_r);
   assign seg_changed_s = (seg_s != seg_prev_r);
   assign en_one_hot_s  = is_one_hot(en_s);

   // Two-flop synchronisers plus one-cycle history of the normalised inputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_meta_r <= 8'h00;
         seg_sync_r <= 8'h00;
         en_meta_r  <= 4'h0;
         en_sync_r  <= 4'h0;
         seg_prev_r <= 8'h00;
         en_prev_r  <= 4'h0;
      end else begin
         seg_meta_r <= seg_in;
         seg_sync_r <= seg_meta_r;
         en_meta_r  <= en_in;
         en_sync_r  <= en_meta_r;
         seg_prev_r <= seg_s;
         en_prev_r  <= en_s;
      end
   end

   // Settle FSM: one capture per enable activation once enable and segments are stable.
   always_comb begin
      state_nxt  = state_r;
      settle_nxt = settle_r;
      capture_s  = 1'b0;
      case (state_r)
         WAIT_EN: begin
            if (en_one_hot_s) begin
               state_nxt  = SETTLING;
               settle_nxt = SETTLE_ONE;
            end else begin
               state_nxt = WAIT_EN;
            end
         end
         SETTLING: begin
            if (en_changed_s) begin
               state_nxt  = en_one_hot_s ? SETTLING : WAIT_EN;
               settle_nxt = SETTLE_ONE;
            end else if (seg_changed_s) begin
               settle_nxt = SETTLE_ONE;
            end else if (settle_r >= SETTLE_MAX) begin
               capture_s = 1'b1;
               state_nxt = HELD;
            end else begin
               settle_nxt = settle_r + SETTLE_ONE;
            end
         end
         HELD: begin
            if (en_changed_s) begin
               state_nxt  = en_one_hot_s ? SETTLING : WAIT_EN;
               settle_nxt = SETTLE_ONE;
            end else begin
               state_nxt = HELD;
            end
         end
         default: begin
            state_nxt  = WAIT_EN;
            settle_nxt = SETTLE_ONE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= WAIT_EN;
         settle_r <= '0;
      end else begin
         state_r  <= state_nxt;
         settle_r <= settle_nxt;
      end
   end

   assign dec_s = decode_seg(seg_s[6:0]);
   assign idx_s = onehot_index(en_s);

   // Working frame after the current capture, if any.
   always_comb begin
      wval_nxt   = wval_r;
      wdp_nxt    = wdp_r;
      wblank_nxt = wblank_r;
      seen_nxt   = seen_r;
      inv_nxt    = inv_r;
      if (capture_s) begin
         wval_nxt[{idx_s, 2'b00} +: 4] = dec_s[3:0];
         wdp_nxt[idx_s]                = seg_s[7];
         wblank_nxt[idx_s]             = dec_s[4];
         seen_nxt                      = seen_r | en_s;
         inv_nxt                       = inv_r | ~dec_s[5];
      end else begin
         seen_nxt = seen_r;
      end
   end

   assign frame_done_s = capture_s && (seen_nxt == 4'hF);
   assign match_s      = (wval_nxt == prev_val_r) && (wdp_nxt == prev_dp_r) &&
                         (wblank_nxt == prev_blank_r);
   assign tmo_nxt      = capture_s ? '0 :
                         ((tmo_r == TIMEOUT_MAX) ? tmo_r : tmo_r + TIMEOUT_ONE);
   assign tmo_hit_s    = !capture_s && (tmo_nxt == TIMEOUT_MAX);
   assign differs_s    = !has_out_r || (wval_nxt != value_r) || (wdp_nxt != dp_r) ||
                         (wblank_nxt != blank_r);

   // Confirmation counter: invalid frames zero it, a differing frame restarts at one.
   always_comb begin
      conf_nxt = conf_r;
      if (frame_done_s) begin
         if (inv_nxt) begin
            conf_nxt = '0;
         end else if (match_s) begin
            conf_nxt = (conf_r >= CONFIRM_MAX) ? conf_r : conf_r + CONFIRM_ONE;
         end else begin
            conf_nxt = CONFIRM_ONE;
         end
      end else if (tmo_hit_s) begin
         conf_nxt = '0;
      end else begin
         conf_nxt = conf_r;
      end
   end

   assign confirm_s = frame_done_s && (conf_nxt == CONFIRM_MAX);

   // Frame buffers, seen mask, invalid flag and timeout counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wval_r       <= 16'h0000;
         wdp_r        <= 4'h0;
         wblank_r     <= 4'h0;
         seen_r       <= 4'h0;
         inv_r        <= 1'b0;
         prev_val_r   <= 16'h0000;
         prev_dp_r    <= 4'h0;
         prev_blank_r <= 4'h0;
         conf_r       <= '0;
         tmo_r        <= '0;
      end else begin
         wval_r   <= wval_nxt;
         wdp_r    <= wdp_nxt;
         wblank_r <= wblank_nxt;
         conf_r   <= conf_nxt;
         tmo_r    <= tmo_nxt;
         if (frame_done_s) begin
            prev_val_r   <= wval_nxt;
            prev_dp_r    <= wdp_nxt;
            prev_blank_r <= wblank_nxt;
            seen_r       <= 4'h0;
            inv_r        <= 1'b0;
         end else if (tmo_hit_s) begin
            seen_r <= 4'h0;
            inv_r  <= 1'b0;
         end else begin
            seen_r <= seen_nxt;
            inv_r  <= inv_nxt;
         end
      end
   end

   // Registered outputs; a confirmed frame also clears the sticky pattern error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_r   <= 16'h0000;
         dp_r      <= 4'h0;
         blank_r   <= 4'h0;
         valid_r   <= 1'b0;
         perr_r    <= 1'b0;
         lost_r    <= 1'b0;
         has_out_r <= 1'b0;
      end else begin
         lost_r <= (tmo_nxt == TIMEOUT_MAX);
         if (confirm_s) begin
            value_r   <= wval_nxt;
            dp_r      <= wdp_nxt;
            blank_r   <= wblank_nxt;
            valid_r   <= differs_s;
            perr_r    <= 1'b0;
            has_out_r <= 1'b1;
         end else begin
            valid_r <= 1'b0;
            if (capture_s && !dec_s[5]) begin
               perr_r <= 1'b1;
            end else begin
               perr_r <= perr_r;
            end
         end
      end
   end

   assign value_out    = value_r;
   assign dp_out       = dp_r;
   assign blank_out    = blank_r;
   assign value_valid  = valid_r;
   assign pattern_err  = perr_r;
   assign display_lost = lost_r;

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// randomized frames checked against a frame-level scoreboard.
module tb_sevenseg_scan_decoder;

   localparam int SETTLE  = 4;
   localparam int CONFIRM = 2;
   localparam int TMO     = 200;
   localparam int HOLD    = 8;

   localparam logic [6:0] HEX2SEG [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   typedef struct {
      logic [31:0] segs;
      bit          ghost;
      logic [15:0] val;
      logic [3:0]  dp;
      logic [3:0]  bl;
      int          pulses;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  seg_in;
   logic [3:0]  en_in;
   logic [15:0] value_out;
   logic [3:0]  dp_out;
   logic [3:0]  blank_out;
   logic        value_valid;
   logic        pattern_err;
   logic        display_lost;

   int          checks = 0;
   int          failures = 0;
   int          pulses = 0;
   logic [15:0] pulse_val = 16'h0000;

   logic [15:0] m_val;
   logic [3:0]  m_dp, m_bl;
   bit          m_first;

   sevenseg_scan_decoder #(
      .SETTLE_CYCLES (SETTLE),
      .CONFIRM_FRAMES(CONFIRM),
      .TIMEOUT_CYCLES(TMO),
      .EN_ACTIVE_LOW (1'b0),
      .SEG_ACTIVE_LOW(1'b0)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .seg_in      (seg_in),
      .en_in       (en_in),
      .value_out   (value_out),
      .dp_out      (dp_out),
      .blank_out   (blank_out),
      .value_valid (value_valid),
      .pattern_err (pattern_err),
      .display_lost(display_lost)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (value_valid) begin
         pulses    <= pulses + 1;
         pulse_val <= value_out;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] encode(input logic [15:0] v, input logic [3:0] dp,
                                          input logic [3:0] bl);
      logic [31:0] s;
      for (int i = 0; i < 4; i++)
         s[8*i +: 8] = bl[i] ? {dp[i], 7'h00} : {dp[i], HEX2SEG[v[4*i +: 4]]};
      return s;
   endfunction

   function automatic logic [15:0] shown_value(input logic [15:0] v, input logic [3:0] bl);
      logic [15:0] r;
      for (int i = 0; i < 4; i++)
         r[4*i +: 4] = bl[i] ? 4'h0 : v[4*i +: 4];
      return r;
   endfunction

   // One full scan, digit 3 first; ghost mode leaks the next segments early and
   // overlaps two enables for one cycle at each digit switch.
   task automatic scan(input logic [31:0] segs, input bit ghost);
      logic [3:0] one;
      one = 4'b0001;
      for (int d = 3; d >= 0; d--) begin
         for (int c = 0; c < HOLD; c++) begin
            en_in  = one << d;
            seg_in = (ghost && c >= HOLD - 2 && d > 0) ? segs[8*(d-1) +: 8] : segs[8*d +: 8];
            tick(1);
         end
         if (ghost && d > 0) begin
            en_in  = (one << d) | (one << (d - 1));
            seg_in = segs[8*(d-1) +: 8];
            tick(1);
         end
      end
   endtask

   task automatic apply_value(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl,
                              input bit ghost, input int nscan, input string tag);
      int          p0;
      logic [15:0] ev;
      int          ep;
      p0 = pulses;
      for (int s = 0; s < nscan; s++) scan(encode(v, dp, bl), ghost);
      tick(4);
      ev = shown_value(v, bl);
      ep = (m_first || ev != m_val || dp != m_dp || bl != m_bl) ? 1 : 0;
      check({tag, "_value"}, value_out, ev);
      check({tag, "_dp"}, dp_out, dp);
      check({tag, "_blank"}, blank_out, bl);
      check({tag, "_pulses"}, pulses - p0, ep);
      check({tag, "_perr"}, pattern_err, 1'b0);
      check({tag, "_lost"}, display_lost, 1'b0);
      m_val = ev; m_dp = dp; m_bl = bl; m_first = 1'b0;
   endtask

   initial begin
      vec_t tbl [5];
      int   p0;
      int   n;
      tbl[0] = '{32'h065B7771, 1'b0, 16'h12AF, 4'h0, 4'h0, 1};
      tbl[1] = '{32'h065B7771, 1'b1, 16'h12AF, 4'h0, 4'h0, 0};
      tbl[2] = '{32'h00ED3F6F, 1'b0, 16'h0509, 4'h4, 4'h8, 1};
      tbl[3] = '{32'hBFBFBFBF, 1'b1, 16'h0000, 4'hF, 4'h0, 1};
      tbl[4] = '{32'h7F7F7F7F, 1'b0, 16'h8888, 4'h0, 4'h0, 1};

      seg_in = 8'h00;
      en_in  = 4'h0;
      rst_n  = 1'b0;
      tick(3);
      check("rst_value", value_out, 16'h0000);
      check("rst_flags", {dp_out, blank_out, value_valid, pattern_err, display_lost}, 11'h000);
      rst_n = 1'b1;
      tick(2);

      for (int i = 0; i < 5; i++) begin
         p0 = pulses;
         for (int s = 0; s < 3; s++) scan(tbl[i].segs, tbl[i].ghost);
         tick(4);
         check("tbl_value", value_out, tbl[i].val);
         check("tbl_dp", dp_out, tbl[i].dp);
         check("tbl_blank", blank_out, tbl[i].bl);
         check("tbl_pulses", pulses - p0, tbl[i].pulses);
         if (tbl[i].pulses > 0) check("tbl_pulse_val", pulse_val, tbl[i].val);
         check("tbl_perr", pattern_err, 1'b0);
      end
      m_val = 16'h8888; m_dp = 4'h0; m_bl = 4'h0; m_first = 1'b0;

      // Undecodable pattern on digit 1, then recovery with clean frames.
      p0 = pulses;
      scan(32'h065B4971, 1'b0);
      tick(4);
      check("err_perr_set", pattern_err, 1'b1);
      check("err_value_held", value_out, 16'h8888);
      scan(32'h3F3F3F3F, 1'b0);
      tick(4);
      check("err_perr_sticky", pattern_err, 1'b1);
      check("err_no_pulse", pulses - p0, 0);
      scan(32'h3F3F3F3F, 1'b0);
      tick(4);
      check("err_recover_value", value_out, 16'h0000);
      check("err_recover_pulse", pulses - p0, 1);
      check("err_perr_clear", pattern_err, 1'b0);
      m_val = 16'h0000;

      // Timeout with enables idle; outputs must hold.
      apply_value(16'h8888, 4'h0, 4'h0, 1'b0, 2, "pre_tmo");
      en_in  = 4'h0;
      seg_in = 8'h00;
      n = 0;
      while (!display_lost && n < 3 * TMO) begin
         tick(1);
         n++;
      end
      check("tmo_asserted", display_lost, 1'b1);
      check("tmo_latency", (n >= TMO - 20 && n <= TMO), 1'b1);
      tick(20);
      check("tmo_sticky", display_lost, 1'b1);
      check("tmo_value_held", value_out, 16'h8888);
      p0 = pulses;
      en_in  = 4'b1000;
      seg_in = {1'b0, HEX2SEG[3]};
      tick(HOLD);
      check("tmo_clear_on_capture", display_lost, 1'b0);
      scan(encode(16'h3C5A, 4'h0, 4'h0), 1'b0);
      tick(2);
      check("tmo_no_early_confirm", pulses - p0, 0);
      check("tmo_value_still_old", value_out, 16'h8888);
      apply_value(16'h3C5A, 4'h0, 4'h0, 1'b0, 1, "tmo_resume");

      // Reset after two digits of a partial frame.
      en_in  = 4'b1000;
      seg_in = {1'b0, HEX2SEG[7]};
      tick(HOLD);
      en_in = 4'b0100;
      tick(HOLD);
      rst_n = 1'b0;
      #1;
      check("mid_rst_value", value_out, 16'h0000);
      check("mid_rst_flags", {dp_out, blank_out, value_valid, pattern_err, display_lost}, 11'h000);
      tick(3);
      rst_n = 1'b1;
      tick(2);
      m_val = 16'h0000; m_dp = 4'h0; m_bl = 4'h0; m_first = 1'b1;
      p0 = pulses;
      scan(encode(16'h7777, 4'h0, 4'h0), 1'b0);
      tick(4);
      check("post_rst_no_pulse", pulses - p0, 0);
      check("post_rst_value", value_out, 16'h0000);
      apply_value(16'h7777, 4'h0, 4'h0, 1'b0, 1, "post_rst");

      // Randomized frames against the scoreboard, with occasional repeats.
      for (int i = 0; i < 20; i++) begin
         logic [15:0] v;
         logic [3:0]  dp, bl;
         if (i % 5 == 4) begin
            v = m_val; dp = m_dp; bl = m_bl;
         end else begin
            v  = 16'($urandom);
            dp = 4'($urandom);
            bl = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
         end
         apply_value(v, dp, bl, 1'($urandom), 2, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
